// File: rtl/btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
//
// Front-end conditioner for the stopwatch push-buttons. Each raw, bouncy,
// asynchronous button pin is passed through a 2-flop synchroniser and a
// debounce FSM. The block produces a clean level plus single-cycle press and
// release pulses per channel. In the stopwatch, btn_press[0] is start/stop and
// btn_press[1] is reset.
//
// Optional feature (compile-time macro BTN_REPEAT_EN): while a button is held,
// extra btn_press pulses are emitted after REPEAT_DELAY cycles and then every
// REPEAT_PERIOD cycles. Without the macro no repeat logic is built.
//
// Parameters:
//   N_BTN           number of independent button channels
//   DEBOUNCE_CYCLES stable synchronised samples needed to accept a change (>=2)
//   REPEAT_DELAY    cycles held before the first auto-repeat pulse
//   REPEAT_PERIOD   cycles between subsequent auto-repeat pulses
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   btn_in       raw button pins, active-high, asynchronous to clk
//   btn_level    debounced button state (registered)
//   btn_press    one-cycle pulse per accepted press / auto-repeat (registered)
//   btn_release  one-cycle pulse per accepted release (registered)
// -----------------------------------------------------------------------------
module btn_conditioner #(
  parameter int N_BTN           = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [CW-1:0] CNT_ZERO = '0;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMING    = 2'd1,
    PRESSED   = 2'd2,
    DISARMING = 2'd3
  } state_t;

  // Reject parameter sets the counters cannot represent.
  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
    $error("btn_conditioner: DEBOUNCE_CYCLES must be >= 2 and repeat timings >= 1");
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_chan
    logic          sync1_r;
    logic          sync2_r;
    state_t        state_r;
    state_t        state_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_s;
    logic          level_r;
    logic          level_s;
    logic          press_r;
    logic          press_s;
    logic          release_r;
    logic          release_s;
    logic          rpt_pulse_s;

    // Two-flop synchroniser for the asynchronous button pin.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_r <= 1'b0;
        sync2_r <= 1'b0;
      end else begin
        sync1_r <= btn_in[g];
        sync2_r <= sync1_r;
      end
    end

    // Debounce FSM: next state, counter and output-event decode from s2 only.
    always_comb begin
      state_s   = state_r;
      cnt_s     = cnt_r;
      level_s   = level_r;
      press_s   = 1'b0;
      release_s = 1'b0;
      case (state_r)
        IDLE: begin
          if (sync2_r) begin
            state_s = ARMING;
            cnt_s   = CNT_ONE;
          end else begin
            state_s = IDLE;
          end
        end
        ARMING: begin
          if (!sync2_r) begin
            // Glitch rejected: fall back quietly.
            state_s = IDLE;
            cnt_s   = CNT_ZERO;
          end else if (cnt_r == CNT_LAST) begin
            state_s = PRESSED;
            cnt_s   = CNT_ZERO;
            level_s = 1'b1;
            press_s = 1'b1;
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end
        PRESSED: begin
          if (!sync2_r) begin
            state_s = DISARMING;
            cnt_s   = CNT_ONE;
          end else begin
            state_s = PRESSED;
          end
        end
        DISARMING: begin
          if (sync2_r) begin
            // Short low glitch while held: stay pressed, no pulse.
            state_s = PRESSED;
            cnt_s   = CNT_ZERO;
          end else if (cnt_r == CNT_LAST) begin
            state_s   = IDLE;
            cnt_s     = CNT_ZERO;
            level_s   = 1'b0;
            release_s = 1'b1;
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_s = IDLE;
          cnt_s   = CNT_ZERO;
          level_s = 1'b0;
        end
      endcase
    end

`ifdef BTN_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW      = $clog2(RPT_MAX + 1);
    localparam logic [RW-1:0] RPT_DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RPT_PERIOD_LAST = RW'(REPEAT_PERIOD - 1);
    localparam logic [RW-1:0] RPT_ONE         = RW'(1'b1);

    logic [RW-1:0] rpt_cnt_r;
    logic [RW-1:0] rpt_cnt_s;
    logic          rpt_first_r;
    logic          rpt_first_s;
    logic [RW-1:0] rpt_last_s;

    // Auto-repeat timer: runs only while staying in PRESSED; any entry or exit
    // restarts it, and the first interval uses the longer delay.
    always_comb begin
      rpt_cnt_s   = rpt_cnt_r;
      rpt_first_s = rpt_first_r;
      rpt_pulse_s = 1'b0;
      rpt_last_s  = rpt_first_r ? RPT_DELAY_LAST : RPT_PERIOD_LAST;
      if (state_r == PRESSED && state_s == PRESSED) begin
        if (rpt_cnt_r == rpt_last_s) begin
          rpt_pulse_s = 1'b1;
          rpt_cnt_s   = '0;
          rpt_first_s = 1'b0;
        end else begin
          rpt_cnt_s = rpt_cnt_r + RPT_ONE;
        end
      end else begin
        rpt_cnt_s   = '0;
        rpt_first_s = 1'b1;
      end
    end

    // Auto-repeat timer registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rpt_cnt_r   <= '0;
        rpt_first_r <= 1'b1;
      end else begin
        rpt_cnt_r   <= rpt_cnt_s;
        rpt_first_r <= rpt_first_s;
      end
    end
`else
    assign rpt_pulse_s = 1'b0;
`endif

    // FSM state, debounce counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_r   <= IDLE;
        cnt_r     <= CNT_ZERO;
        level_r   <= 1'b0;
        press_r   <= 1'b0;
        release_r <= 1'b0;
      end else begin
        state_r   <= state_s;
        cnt_r     <= cnt_s;
        level_r   <= level_s;
        press_r   <= press_s | rpt_pulse_s;
        release_r <= release_s;
      end
    end

    assign btn_level[g]   = level_r;
    assign btn_press[g]   = press_r;
    assign btn_release[g] = release_r;
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// -----------------------------------------------------------------------------
// tb_btn_conditioner
//
// Directed self-checking bench for btn_conditioner with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=20, REPEAT_PERIOD=8. Inputs change 1 ns after a rising edge;
// outputs are sampled at the same point, i.e. just after each edge.
// -----------------------------------------------------------------------------
module tb_btn_conditioner;

  logic       clk;
  logic       rst_n;
  logic [1:0] btn_in;
  logic [1:0] btn_level;
  logic [1:0] btn_press;
  logic [1:0] btn_release;

  int n_chk;
  int n_fail;

  btn_conditioner #(
    .N_BTN(2),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(20),
    .REPEAT_PERIOD(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_in(btn_in),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .btn_release(btn_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] lvl,
                         input logic [1:0] prs, input logic [1:0] rel);
    chk({tag, ".level"},   btn_level,   lvl);
    chk({tag, ".press"},   btn_press,   prs);
    chk({tag, ".release"}, btn_release, rel);
  endtask

  // Caller has just changed btn_in; the next edge is E0. Outputs stay quiet
  // through E0+4 and the event shows after E0+5, then pulses drop after E0+6.
  task automatic expect_event(input string tag, input logic [1:0] lvl_before,
                              input logic [1:0] lvl_after, input logic [1:0] prs,
                              input logic [1:0] rel);
    for (int k = 0; k < 5; k++) begin
      tick(1);
      chk_all({tag, ".quiet"}, lvl_before, 2'b00, 2'b00);
    end
    tick(1);
    chk_all({tag, ".event"}, lvl_after, prs, rel);
    tick(1);
    chk_all({tag, ".after"}, lvl_after, 2'b00, 2'b00);
  endtask

  initial begin
    logic [1:0] exp_p;
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    btn_in = 2'b00;
    tick(2);
    chk_all("reset_hold", 2'b00, 2'b00, 2'b00);
    rst_n = 1'b1;
    tick(2);
    chk_all("idle", 2'b00, 2'b00, 2'b00);

    // Clean press on channel 0, held with no further pulses, then release.
    btn_in = 2'b01;
    expect_event("press0", 2'b00, 2'b01, 2'b01, 2'b00);
    for (int k = 0; k < 8; k++) begin
      tick(1);
      chk_all("hold0", 2'b01, 2'b00, 2'b00);
    end
    btn_in = 2'b00;
    expect_event("release0", 2'b01, 2'b00, 2'b00, 2'b01);
    tick(2);

    // Bounce 1,1,0,1,1,0 never reaches four stable samples.
    begin
      logic [5:0] pat;
      pat = 6'b011011;
      for (int k = 0; k < 6; k++) begin
        btn_in = {1'b0, pat[k]};
        tick(1);
        chk_all("bounce", 2'b00, 2'b00, 2'b00);
      end
    end
    for (int k = 0; k < 6; k++) begin
      tick(1);
      chk_all("bounce_settle", 2'b00, 2'b00, 2'b00);
    end
    btn_in = 2'b01;
    expect_event("press_after_bounce", 2'b00, 2'b01, 2'b01, 2'b00);

    // Two-cycle low glitch while pressed: no release.
    btn_in = 2'b00;
    tick(2);
    btn_in = 2'b01;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      chk_all("release_glitch", 2'b01, 2'b00, 2'b00);
    end
    btn_in = 2'b00;
    expect_event("release_after_glitch", 2'b01, 2'b00, 2'b00, 2'b01);
    tick(2);

    // Both channels rising on the same edge.
    btn_in = 2'b11;
    expect_event("press_both", 2'b00, 2'b11, 2'b11, 2'b00);
    btn_in = 2'b00;
    expect_event("release_both", 2'b11, 2'b00, 2'b00, 2'b11);
    tick(2);

    // Channel 1 starts 3 edges after channel 0.
    btn_in = 2'b01;
    tick(1);
    chk_all("stagger_e0", 2'b00, 2'b00, 2'b00);
    tick(1);
    chk_all("stagger_e1", 2'b00, 2'b00, 2'b00);
    tick(1);
    chk_all("stagger_e2", 2'b00, 2'b00, 2'b00);
    btn_in = 2'b11;
    tick(1);
    chk_all("stagger_e3", 2'b00, 2'b00, 2'b00);
    tick(1);
    chk_all("stagger_e4", 2'b00, 2'b00, 2'b00);
    tick(1);
    chk_all("stagger_e5", 2'b01, 2'b01, 2'b00);
    tick(1);
    chk_all("stagger_e6", 2'b01, 2'b00, 2'b00);
    tick(1);
    chk_all("stagger_e7", 2'b01, 2'b00, 2'b00);
    tick(1);
    chk_all("stagger_e8", 2'b11, 2'b10, 2'b00);
    tick(1);
    chk_all("stagger_e9", 2'b11, 2'b00, 2'b00);

    // Asynchronous reset while both held: outputs clear before any edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_reset", 2'b00, 2'b00, 2'b00);
    tick(2);
    chk_all("reset_held_btn", 2'b00, 2'b00, 2'b00);
    rst_n = 1'b1;
    expect_event("press_after_reset", 2'b00, 2'b11, 2'b11, 2'b00);
    btn_in = 2'b00;
    expect_event("release_after_reset", 2'b11, 2'b00, 2'b00, 2'b11);
    tick(2);

    // Long hold on channel 0: repeat pulses at +20, +28, +36, +44 when enabled.
    btn_in = 2'b01;
    expect_event("press_long", 2'b00, 2'b01, 2'b01, 2'b00);
    for (int k = 2; k <= 47; k++) begin
      tick(1);
`ifdef BTN_REPEAT_EN
      exp_p = (k == 20 || k == 28 || k == 36 || k == 44) ? 2'b01 : 2'b00;
`else
      exp_p = 2'b00;
`endif
      chk_all($sformatf("hold_long_%0d", k), 2'b01, exp_p, 2'b00);
    end
    btn_in = 2'b00;
    expect_event("release_long", 2'b01, 2'b00, 2'b00, 2'b01);
    for (int k = 0; k < 10; k++) begin
      tick(1);
      chk_all("after_long", 2'b00, 2'b00, 2'b00);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Front-end conditioner for the stopwatch's push-buttons. Sits directly upstream of the stopwatch control FSM.
- Takes raw, bouncy, asynchronous button pins and synchronises and debounces each one.
- Emits a clean level plus single-cycle press and release pulses per button.
- Stopwatch wiring: btn_press[0] drives start/stop, btn_press[1] drives reset.

Parameters:
- N_BTN, 2: number of independent button channels.
- DEBOUNCE_CYCLES, 500000: consecutive stable synchronised samples needed to accept a change (5 ms at 100 MHz). Must be >= 2.
- REPEAT_DELAY, 50000000: cycles held before the first auto-repeat pulse (optional feature only).
- REPEAT_PERIOD, 10000000: cycles between subsequent auto-repeat pulses (optional feature only).

Ports:
- clk, input, 1: system clock; all state is on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- btn_in, input, N_BTN: raw button pins, active-high, asynchronous to clk.
- btn_level, output, N_BTN: debounced button state, registered.
- btn_press, output, N_BTN: one-cycle pulse on an accepted press (and on auto-repeat, if enabled), registered.
- btn_release, output, N_BTN: one-cycle pulse on an accepted release, registered.

Behaviour:
- Reset: asynchronous on rst_n low. Clears all outputs to 0, synchroniser flops to 0, all counters to 0 and every channel FSM to IDLE.
  - Deassertion takes effect on the next clk edge.
  - Reset mid-debounce or mid-hold discards progress; a press in progress is never reported.
- Per channel, fully independent (generate loop): a 2-flop synchroniser s1 -> s2 feeds the FSM. The FSM and counters sample s2 only.
- Debounce counter: width = ceil(log2(DEBOUNCE_CYCLES+1)); saturation is never needed.
- FSM states: IDLE (stable low), ARMING, PRESSED (stable high), DISARMING.
  - IDLE: s2=1 -> ARMING, cnt=1; else stay.
  - ARMING: s2=0 -> IDLE, cnt=0 (glitch rejected, no pulse). s2=1 with cnt==DEBOUNCE_CYCLES-1 -> PRESSED; btn_level<=1, btn_press<=1. Otherwise cnt++.
  - PRESSED: s2=0 -> DISARMING, cnt=1; else stay.
  - DISARMING: s2=1 -> PRESSED, cnt=0 (no pulse). s2=0 with cnt==DEBOUNCE_CYCLES-1 -> IDLE; btn_level<=0, btn_release<=1. Otherwise cnt++.
- Latency: let E0 be the first edge sampling btn_in high, with btn_in held high through edge E0+DEBOUNCE_CYCLES.
  - btn_level rises and btn_press pulses in the cycle after edge E0+DEBOUNCE_CYCLES+1.
  - Release is symmetric.
- Pulse rules:
  - btn_press and btn_release are high for exactly one cycle per event and are never high together on one channel.
  - Both default to 0 on every cycle without an event.
- Simultaneous events on different channels are independent; multiple bits may pulse in the same cycle.
- Bounce shorter than DEBOUNCE_CYCLES samples produces no output change.

Optional Feature:
- Macro: BTN_REPEAT_EN.
- Defined:
  - Each channel has a repeat counter, width ceil(log2(max(REPEAT_DELAY,REPEAT_PERIOD)+1)).
  - The counter clears on entry to PRESSED and counts while in PRESSED.
  - On reaching REPEAT_DELAY it emits an extra btn_press pulse and reloads to count REPEAT_PERIOD; it repeats every REPEAT_PERIOD while held.
  - The counter clears on entering DISARMING. A return from DISARMING to PRESSED restarts from 0 with no pulse.
  - btn_level is unaffected.
- Not defined: no repeat logic or counters are synthesised; btn_press pulses once per accepted press.

Test Plan:
- Reset: drive rst_n=0 with btn_in=2'b11 mid-run -> all outputs 0 immediately (asynchronous); FSM in IDLE. After release, a fresh full debounce is required before any press.
- Clean press, DEBOUNCE_CYCLES=4: btn_in[0] held high from edge E0 -> btn_level[0] and a one-cycle btn_press[0] after edge E0+5, then no further pulses while held. Releasing gives one btn_release[0] 6 edges after the first low sample.
- Bounce rejection, DEBOUNCE_CYCLES=4: btn_in[0] toggles 1,1,0,1,1,0 per cycle -> no press, btn_level stays 0. A following stable high gives exactly one press.
- Release glitch, DEBOUNCE_CYCLES=4: while PRESSED, drive a 2-cycle low -> no release pulse, btn_level stays 1.
- Two channels: btn_in=2'b11 rising on the same edge -> btn_press=2'b11 in the same cycle. Staggered by 3 cycles -> pulses 3 cycles apart.
- With BTN_REPEAT_EN, DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, held 50 cycles after acceptance -> press pulses at +0, +20, +28, +36, +44; none after release.
